// File: rtl/qj_serial_adder.sv
// Multi-cycle add/subtract: K operand bits per enabled cycle, LSB slice first.
// Results are captured on the final slice and held until the next operation.
module qj_serial_adder #(
   parameter int WIDTH = 8,
   parameter int K     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       E,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] Ai,
   input  logic [WIDTH-1:0] Bi,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Si,
   output logic             Co,
   output logic             Ov
);

   localparam int NSTEP = WIDTH / K;
   localparam int CW    = $clog2(NSTEP + 1);

   generate
      if (WIDTH < 2 || K < 1 || (WIDTH % K) != 0) begin : g_bad_params
         $error("qj_serial_adder: WIDTH must be >= 2 and K must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_si;
   logic             r_co, r_ov;

   logic             w_en;
   logic             w_last;
   logic [K:0]       w_sum;
   logic             w_cmsb;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_en   = E[2] & ~E[1] & ~E[0];
   assign w_last = (r_cnt == CW'(NSTEP - 1));
   assign w_sum  = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]} + {{K{1'b0}}, r_carry};
   // Carry into the slice's top bit, recovered from its sum and operand bits.
   assign w_cmsb = w_sum[K-1] ^ r_a[K-1] ^ r_b[K-1];

   generate
      if (K == WIDTH) begin : g_res_full
         assign w_res_nxt = w_sum[K-1:0];
      end else begin : g_res_shift
         assign w_res_nxt = {w_sum[K-1:0], r_res[WIDTH-1:K]};
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start && w_en) w_state_nxt = S_RUN;
         S_RUN:   if (w_en && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_si    <= '0;
         r_co    <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && start && w_en) begin
            r_a     <= Ai;
            r_b     <= sub ? ~Bi : Bi;
            r_carry <= sub ? 1'b1 : Cin;
            r_cnt   <= '0;
         end else if (r_state == S_RUN && w_en) begin
            r_a     <= r_a >> K;
            r_b     <= r_b >> K;
            r_carry <= w_sum[K];
            r_res   <= w_res_nxt;
            r_cnt   <= r_cnt + CW'(1);
            // Final slice: publish so outputs are valid throughout DONE.
            if (w_last) begin
               r_si <= w_res_nxt;
               r_co <= w_sum[K];
               r_ov <= w_cmsb ^ w_sum[K];
            end
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign Si   = r_si;
   assign Co   = r_co;
   assign Ov   = r_ov;

endmodule

// File: tb/tb_qj_serial_adder.sv
// Randomized check of qj_serial_adder (K=1 and K=4 instances, WIDTH=8)
// against an arithmetic reference model.
module tb_qj_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] E = 3'b100;
   logic [2:0] E4 = 3'b100;
   logic       start = 1'b0, start4 = 1'b0;
   logic       sub = 1'b0, Cin = 1'b0;
   logic [7:0] Ai = '0, Bi = '0;

   logic       busy, done, Co, Ov;
   logic [7:0] Si;
   logic       busy4, done4, Co4, Ov4;
   logic [7:0] Si4;

   int n_chk = 0;
   int n_fail = 0;
   logic [9:0] prev = '0;   // {Ov,Co,Si} of the last completed op

   always #5 clk = ~clk;

   qj_serial_adder #(.WIDTH(8), .K(1)) dut (
      .clk(clk), .rst(rst), .E(E), .start(start), .sub(sub), .Ai(Ai), .Bi(Bi),
      .Cin(Cin), .busy(busy), .done(done), .Si(Si), .Co(Co), .Ov(Ov));

   qj_serial_adder #(.WIDTH(8), .K(4)) dut4 (
      .clk(clk), .rst(rst), .E(E4), .start(start4), .sub(sub), .Ai(Ai), .Bi(Bi),
      .Cin(Cin), .busy(busy4), .done(done4), .Si(Si4), .Co(Co4), .Ov(Ov4));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // {Ov,Co,Si} from plain arithmetic and the sign rule for overflow
   function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic c);
      logic [7:0] bop;
      int         full;
      logic [7:0] res;
      logic       ov;
      bop  = s ? ~b : b;
      full = int'(a) + int'(bop) + (s ? 1 : int'(c));
      res  = full[7:0];
      ov   = (a[7] == bop[7]) && (res[7] != a[7]);
      return {ov, full[8], res};
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic c, input int stall_at, input int stall_len,
                         input bit poke);
      logic [9:0] exp;
      int dn, dn4, bcnt, bcnt4, dcnt, dcnt4, exp_dn;
      exp = ref_op(a, b, s, c);
      exp_dn = 9 + stall_len;
      dn = 0; dn4 = 0; bcnt = 0; bcnt4 = 0; dcnt = 0; dcnt4 = 0;
      @(negedge clk);
      Ai = a; Bi = b; sub = s; Cin = c; E = 3'b100; start = 1'b1; start4 = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) chk("hold_before_done", {Ov, Co, Si}, prev);
         bcnt  += int'(busy);
         bcnt4 += int'(busy4);
         if (done) begin
            dcnt++;
            if (dn == 0) begin
               dn = n;
               chk("result", {Ov, Co, Si}, exp);
            end
         end
         if (done4) begin
            dcnt4++;
            if (dn4 == 0) begin
               dn4 = n;
               chk("result_k4", {Ov4, Co4, Si4}, exp);
            end
         end
         if (dn != 0 && n > dn) begin
            chk("hold_after_done", {Ov, Co, Si}, exp);
            break;
         end
         // operand inputs wander during RUN; they must not matter
         Ai = 8'($urandom); Bi = 8'($urandom); sub = 1'($urandom); Cin = 1'($urandom);
         E = (n >= stall_at && n < stall_at + stall_len) ? 3'b000 : 3'b100;
         start = (poke && n == exp_dn) ? 1'b1 : 1'b0;
         start4 = 1'b0;
      end
      start = 1'b0; E = 3'b100;
      if (dn == 0) chk("timeout", 32'd0, 32'd1);
      chk("done_cycle", dn, exp_dn);
      chk("busy_cycles", bcnt, 8 + stall_len);
      chk("done_pulses", dcnt, 1);
      chk("done_cycle_k4", dn4, 3);
      chk("busy_cycles_k4", bcnt4, 2);
      chk("done_pulses_k4", dcnt4, 1);
      prev = exp;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_outs", {busy, done, Ov, Co, Si}, '0);
      chk("reset_outs_k4", {busy4, done4, Ov4, Co4, Si4}, '0);
      rst = 1'b0;

      run_op(8'd200, 8'd100, 1'b0, 1'b0, 0, 0, 1'b0);
      run_op(8'hFF, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
      run_op(8'd5, 8'd7, 1'b1, 1'b1, 0, 0, 1'b0);
      run_op(8'h80, 8'h01, 1'b1, 1'b0, 0, 0, 1'b0);
      run_op(8'd127, 8'd1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_op(8'h9A, 8'h77, 1'b0, 1'b0, 0, 0, 1'b0);
      run_op(8'd200, 8'd100, 1'b0, 1'b0, 3, 3, 1'b1);   // stall + start during DONE

      // start with E=110 must be refused
      @(negedge clk);
      E = 3'b110; start = 1'b1;
      @(negedge clk);
      chk("blocked_busy", {busy, done}, 2'b00);
      start = 1'b0; E = 3'b100;
      @(negedge clk);
      chk("blocked_idle", {busy, done, Ov, Co, Si}, {2'b00, prev});

      for (int i = 0; i < 20; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom));

      // reset mid-operation abandons it
      @(negedge clk);
      Ai = 8'h55; Bi = 8'h3C; sub = 1'b0; Cin = 1'b0; start = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start = 1'b0; start4 = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", {busy, done, Ov, Co, Si}, '0);
      chk("rst_mid_outs_k4", {busy4, done4, Ov4, Co4, Si4}, '0);
      rst = 1'b0;
      begin
         int dseen;
         dseen = 0;
         repeat (12) begin
            @(negedge clk);
            dseen += int'(done) + int'(busy);
         end
         chk("no_done_after_rst", dseen, 0);
      end
      prev = '0;
      run_op(8'd127, 8'd1, 1'b0, 1'b0, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
